// File: rtl/vigna_axi_ram.sv
// vigna_axi_ram: AXI4-Lite slave word memory, one read and one write in flight at a time.
// Define VIGNA_AXI_RAM_LATENCY_EN to add LATENCY wait cycles before rvalid/bvalid.
module vigna_axi_ram #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [31:0] araddr_i,
  input  logic [2:0]  arprot_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic [1:0]  rresp_o,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [31:0] awaddr_i,
  input  logic [2:0]  awprot_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        bvalid_o,
  input  logic        bready_i,
  output logic [1:0]  bresp_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {RIdle, RWait, RResp} r_state_e;
  typedef enum logic [2:0] {WIdle, WHaveA, WHaveD, WWait, WResp} w_state_e;

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;

  logic [31:0] mem_q [DEPTH];

  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

`ifdef VIGNA_AXI_RAM_LATENCY_EN
  localparam logic [3:0] LatInit = 4'(LATENCY - 1);
  logic [3:0] rcnt_q, rcnt_d;
  logic [3:0] wcnt_q, wcnt_d;
`endif

  // Protection bits and byte offsets carry no meaning for a word memory.
  logic unused_ok;
  assign unused_ok = ^{arprot_i, awprot_i, araddr_i[1:0], awaddr_i[1:0]} ^ (LATENCY > 15);

  // ---------------- Read channel ----------------
  logic          ar_hs;
  logic          rd_oob;
  logic [AW-1:0] rd_idx;

  assign arready_o = (r_state_q == RIdle) & ~reset_i;
  assign rvalid_o  = (r_state_q == RResp);
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign ar_hs     = arvalid_i & arready_o;
  assign rd_idx    = araddr_i[AW+1:2];
  assign rd_oob    = |(araddr_i >> (AW + 2));

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
`ifdef VIGNA_AXI_RAM_LATENCY_EN
    rcnt_d    = rcnt_q;
`endif
    unique case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          rdata_d = rd_oob ? '0 : mem_q[rd_idx];
          rresp_d = rd_oob ? RespSlvErr : RespOkay;
`ifdef VIGNA_AXI_RAM_LATENCY_EN
          if (LATENCY != 0) begin
            r_state_d = RWait;
            rcnt_d    = LatInit;
          end else begin
            r_state_d = RResp;
          end
`else
          r_state_d = RResp;
`endif
        end
      end
`ifdef VIGNA_AXI_RAM_LATENCY_EN
      RWait: begin
        if (rcnt_q == 4'd0) r_state_d = RResp;
        else                rcnt_d    = rcnt_q - 4'd1;
      end
`endif
      RResp: begin
        if (rready_i) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
  end

  // ---------------- Write channel ----------------
  logic          aw_hs, w_hs;
  logic          have_a, have_d, wr_commit, wr_oob, mem_we;
  logic [31:0]   wr_addr, wr_data;
  logic [3:0]    wr_strb;
  logic [AW-1:0] wr_idx;

  assign awready_o = ((w_state_q == WIdle) | (w_state_q == WHaveD)) & ~reset_i;
  assign wready_o  = ((w_state_q == WIdle) | (w_state_q == WHaveA)) & ~reset_i;
  assign bvalid_o  = (w_state_q == WResp);
  assign bresp_o   = bresp_q;

  assign aw_hs   = awvalid_i & awready_o;
  assign w_hs    = wvalid_i & wready_o;
  // Use the live channel when it is handshaking now, otherwise the latched copy.
  assign wr_addr = aw_hs ? awaddr_i : waddr_q;
  assign wr_data = w_hs ? wdata_i : wdata_q;
  assign wr_strb = w_hs ? wstrb_i : wstrb_q;
  assign wr_idx  = wr_addr[AW+1:2];
  assign wr_oob  = |(wr_addr >> (AW + 2));

  assign have_a    = aw_hs | (w_state_q == WHaveA);
  assign have_d    = w_hs | (w_state_q == WHaveD);
  assign wr_commit = have_a & have_d;
  assign mem_we    = wr_commit & ~wr_oob;

  always_comb begin
    w_state_d = w_state_q;
    bresp_d   = bresp_q;
    waddr_d   = aw_hs ? awaddr_i : waddr_q;
    wdata_d   = w_hs ? wdata_i : wdata_q;
    wstrb_d   = w_hs ? wstrb_i : wstrb_q;
`ifdef VIGNA_AXI_RAM_LATENCY_EN
    wcnt_d    = wcnt_q;
`endif
    unique case (w_state_q)
      WIdle, WHaveA, WHaveD: begin
        if (wr_commit) begin
          bresp_d = wr_oob ? RespSlvErr : RespOkay;
`ifdef VIGNA_AXI_RAM_LATENCY_EN
          if (LATENCY != 0) begin
            w_state_d = WWait;
            wcnt_d    = LatInit;
          end else begin
            w_state_d = WResp;
          end
`else
          w_state_d = WResp;
`endif
        end else if (aw_hs) begin
          w_state_d = WHaveA;
        end else if (w_hs) begin
          w_state_d = WHaveD;
        end
      end
`ifdef VIGNA_AXI_RAM_LATENCY_EN
      WWait: begin
        if (wcnt_q == 4'd0) w_state_d = WResp;
        else                wcnt_d    = wcnt_q - 4'd1;
      end
`endif
      WResp: begin
        if (bready_i) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  // ---------------- State registers ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state_q <= RIdle;
      w_state_q <= WIdle;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
      bresp_q   <= RespOkay;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
`ifdef VIGNA_AXI_RAM_LATENCY_EN
      rcnt_q    <= '0;
      wcnt_q    <= '0;
`endif
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
`ifdef VIGNA_AXI_RAM_LATENCY_EN
      rcnt_q    <= rcnt_d;
      wcnt_q    <= wcnt_d;
`endif
    end
  end

  // Array is never reset; a read in the same cycle sees the pre-write contents.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vigna_axi_ram.sv
// tb_vigna_axi_ram: directed and random AXI4-Lite traffic against a word-array reference model.
module tb_vigna_axi_ram;
  localparam int unsigned Depth = 1024;
  localparam int          Words = 64;
`ifdef VIGNA_AXI_RAM_LATENCY_EN
  localparam int          Lat   = 3;
`else
  localparam int          Lat   = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] araddr, rdata;
  logic [1:0]  rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [Words];

  always #5 clk = ~clk;

  vigna_axi_ram #(
    .DEPTH  (Depth),
    .LATENCY(3)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .arvalid_i(arvalid),
    .arready_o(arready),
    .araddr_i (araddr),
    .arprot_i (3'b000),
    .rvalid_o (rvalid),
    .rready_i (rready),
    .rdata_o  (rdata),
    .rresp_o  (rresp),
    .awvalid_i(awvalid),
    .awready_o(awready),
    .awaddr_i (awaddr),
    .awprot_i (3'b000),
    .wvalid_i (wvalid),
    .wready_o (wready),
    .wdata_i  (wdata),
    .wstrb_i  (wstrb),
    .bvalid_o (bvalid),
    .bready_i (bready),
    .bresp_o  (bresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    logic [31:0] m;
    r = old;
    for (int i = 0; i < 4; i++) begin
      m = 32'hFF << (8 * i);
      if (strb[i]) r = (r & ~m) | (nw & m);
    end
    return r;
  endfunction

  // mode 0: AW and W together; 1: W three cycles ahead of AW; 2: AW three cycles ahead of W.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int mode, output logic [1:0] resp);
    int t;
    int n;
    bit a_done, d_done, a_hs, d_hs;
    t = 0;
    a_done = 0;
    d_done = 0;
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    if (mode != 1) awvalid = 1'b1;
    if (mode != 2) wvalid = 1'b1;
    while (!(a_done && d_done) && t < 40) begin
      if (t == 3 && mode == 1) awvalid = 1'b1;
      if (t == 3 && mode == 2) wvalid = 1'b1;
      if (mode == 1 && t == 2) chk("w_held_off", 32'(wready), 32'd0);
      if (mode == 2 && t == 2) chk("aw_held_off", 32'(awready), 32'd0);
      a_hs = awvalid && awready;
      d_hs = wvalid && wready;
      @(posedge clk);
      @(negedge clk);
      t++;
      if (a_hs) begin awvalid = 1'b0; a_done = 1; end
      if (d_hs) begin wvalid = 1'b0; d_done = 1; end
    end
    chk("w_accept", 32'({a_done, d_done}), 32'd3);
    n = 1;
    while (!bvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b_latency", n, 1 + Lat);
    chk("b_busy", 32'({awready, wready}), 32'd0);
    resp = bresp;
    bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    chk("b_single", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ar_ready", 32'(arready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("r_latency", n, 1 + Lat);
    chk("ar_busy", 32'(arready), 32'd0);
    data = rdata;
    resp = rresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("r_hold_valid", 32'(rvalid), 32'd1);
      chk("r_hold_data", rdata, data);
    end
    rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0;
    chk("r_single", 32'(rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] d, nw, old, addr;
    logic [1:0]  r;
    logic [5:0]  idx;
    logic [3:0]  s;
    bit          oob;
    int          n;

    reset = 1'b1;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_handshakes", 32'({arready, awready, wready, rvalid, bvalid}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", 32'({rresp, bresp}), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 32'({arready, awready, wready}), 32'd7);
    @(negedge clk);

    for (int i = 0; i < Words; i++) begin
      d = $urandom;
      axi_write(32'(i) << 2, d, 4'hF, 0, r);
      model[6'(i)] = d;
      chk("init_bresp", 32'(r), 32'd0);
    end

    axi_write(32'h10, 32'h0000_002A, 4'hF, 0, r);
    model[4] = 32'h0000_002A;
    chk("basic_bresp", 32'(r), 32'd0);
    axi_read(32'h10, 0, d, r);
    chk("basic_rdata", d, 32'h0000_002A);
    chk("basic_rresp", 32'(r), 32'd0);

    axi_write(32'h14, 32'h1122_3344, 4'hF, 0, r);
    axi_write(32'h14, 32'hAABB_CCDD, 4'b0101, 0, r);
    model[5] = 32'h11BB_33DD;
    axi_read(32'h14, 0, d, r);
    chk("strobe_rdata", d, 32'h11BB_33DD);

    axi_write(32'h18, 32'hCAFE_0001, 4'hF, 1, r);
    axi_write(32'h1C, 32'hCAFE_0002, 4'hF, 0, r);
    axi_write(32'h1B, 32'hCAFE_0003, 4'b0011, 2, r);
    model[6] = 32'hCAFE_0001;
    model[7] = 32'hCAFE_0002;
    model[6] = merge(model[6], 32'hCAFE_0003, 4'b0011);
    axi_read(32'h18, 0, d, r);
    chk("w_first_rdata", d, model[6]);
    axi_read(32'h1C, 0, d, r);
    chk("same_cycle_rdata", d, model[7]);

    axi_read(32'h1000, 0, d, r);
    chk("oob_rdata", d, 32'd0);
    chk("oob_rresp", 32'(r), 32'd2);
    axi_write(32'h1000, 32'hDEAD_BEEF, 4'hF, 0, r);
    chk("oob_bresp", 32'(r), 32'd2);
    axi_read(32'h0, 0, d, r);
    chk("oob_word0", d, model[0]);
    chk("oob_word0_resp", 32'(r), 32'd0);

    axi_read(32'h14, 5, d, r);
    chk("bp_rdata", d, model[5]);

    // Read and write to the same word in one cycle: read returns old contents.
    nw = $urandom;
    old = model[8];
    araddr = 32'h20; awaddr = 32'h20; wdata = nw; wstrb = 4'hF;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    model[8] = nw;
    n = 1;
    while (!(rvalid && bvalid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("coll_latency", n, 1 + Lat);
    chk("coll_old_data", rdata, old);
    rready = 1'b1; bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    axi_read(32'h20, 0, d, r);
    chk("coll_new_data", d, nw);

    for (int k = 0; k < 150; k++) begin
      idx = 6'($urandom_range(Words - 1, 0));
      oob = ($urandom_range(7, 0) == 0);
      addr = oob ? 32'($urandom_range(32'hFFFF_FFFF, 4 * Depth))
                 : ({26'd0, idx} << 2) | 32'($urandom_range(3, 0));
      if ($urandom_range(1, 0) == 1) begin
        nw = $urandom;
        s = 4'($urandom_range(15, 0));
        axi_write(addr, nw, s, int'($urandom_range(2, 0)), r);
        if (!oob) model[idx] = merge(model[idx], nw, s);
        chk("rnd_bresp", 32'(r), oob ? 32'd2 : 32'd0);
      end else begin
        axi_read(addr, 0, d, r);
        chk("rnd_rdata", d, oob ? 32'd0 : model[idx]);
        chk("rnd_rresp", 32'(r), oob ? 32'd2 : 32'd0);
      end
    end

    // Reset while a write response is pending: response dropped, data kept.
    nw = $urandom;
    awaddr = 32'h24; wdata = nw; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    model[9] = nw;
    n = 1;
    while (!bvalid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_bvalid", 32'(bvalid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_bdrop", 32'(bvalid), 32'd0);
    chk("rst_mid_ready", 32'({arready, awready, wready}), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    axi_read(32'h24, 0, d, r);
    chk("rst_mid_kept", d, nw);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
